// File: rtl/keypad_scanner_if.sv
// Keypad matrix pins plus the decoded key event bus toward the game-state logic.
interface keypad_scanner_if;
  logic [3:0] key_row;
  logic [2:0] key_col;
  logic [3:0] key_data;
  logic       key_valid;
  logic       key_held;

  // Scanner side: senses rows, drives columns and the key event outputs.
  modport master (
    input  key_row,
    output key_col,
    output key_data,
    output key_valid,
    output key_held
  );

  // Keypad/consumer side.
  modport slave (
    output key_row,
    input  key_col,
    input  key_data,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 3x4 keypad scanner: column scan, per-tick debounce, one event per press.
module keypad_scanner #(
  parameter int unsigned CLK_DIV        = 25000,
  parameter int unsigned DEBOUNCE_TICKS = 20
) (
  input  logic                clk,
  input  logic                rst,
  keypad_scanner_if.master    kp
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_TICKS + 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [3:0]       row_s1, row_s2;
  logic [1:0]       col_idx, col_idx_n;
  logic [1:0]       row_idx, row_idx_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [1:0]       col_adv;
  logic [1:0]       row_low;
  logic             row_hit;
  logic [2:0]       key_col_n;
  logic [3:0]       key_data_n;
  logic             key_valid_n;
  logic             key_held_n;

  // Map matrix position to key code: 1-9 on the cell rows, '*'=10, '0'=0, '#'=11.
  function automatic logic [3:0] key_code(input logic [1:0] c, input logic [1:0] r);
    logic [3:0] rr;
    logic [3:0] cc;
    rr = {2'b00, r};
    cc = {2'b00, c};
    if (r == 2'd3) begin
      case (c)
        2'd0:    return 4'd10;
        2'd2:    return 4'd11;
        default: return 4'd0;
      endcase
    end
    return rr * 4'd3 + cc + 4'd1;
  endfunction

  assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

  // Scan tick prescaler.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_W'(1);
  end

  // Two-flop synchronizer for the asynchronous row sense lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_s1 <= '0;
      row_s2 <= '0;
    end else begin
      row_s1 <= kp.key_row;
      row_s2 <= row_s1;
    end
  end

  // Scan/debounce state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= SCAN;
      col_idx      <= '0;
      row_idx      <= '0;
      cnt          <= '0;
      kp.key_col   <= 3'b001;
      kp.key_data  <= '0;
      kp.key_valid <= 1'b0;
      kp.key_held  <= 1'b0;
    end else begin
      state        <= state_n;
      col_idx      <= col_idx_n;
      row_idx      <= row_idx_n;
      cnt          <= cnt_n;
      kp.key_col   <= key_col_n;
      kp.key_data  <= key_data_n;
      kp.key_valid <= key_valid_n;
      kp.key_held  <= key_held_n;
    end
  end

  // Next-state and output decode; everything only moves on a scan tick.
  always_comb begin
    state_n     = state;
    col_idx_n   = col_idx;
    row_idx_n   = row_idx;
    cnt_n       = cnt;
    key_col_n   = kp.key_col;
    key_data_n  = kp.key_data;
    key_valid_n = 1'b0;
    key_held_n  = kp.key_held;
    cnt_inc     = cnt + CNT_W'(1);
    col_adv     = (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
    row_hit     = row_s2[row_idx];
    row_low     = row_s2[0] ? 2'd0 : row_s2[1] ? 2'd1 : row_s2[2] ? 2'd2 : 2'd3;

    if (tick) begin
      unique case (state)
        SCAN: begin
          if (|row_s2) begin
            state_n   = DEBOUNCE;
            row_idx_n = row_low;
            cnt_n     = CNT_W'(1);
          end else begin
            col_idx_n = col_adv;
            key_col_n = 3'b001 << col_adv;
          end
        end
        DEBOUNCE: begin
          if (row_hit) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_W'(DEBOUNCE_TICKS)) begin
              state_n     = HELD;
              cnt_n       = '0;
              key_data_n  = key_code(col_idx, row_idx);
              key_valid_n = 1'b1;
              key_held_n  = 1'b1;
            end
          end else begin
            state_n   = SCAN;
            cnt_n     = '0;
            col_idx_n = col_adv;
            key_col_n = 3'b001 << col_adv;
          end
        end
        HELD: begin
          if (!row_hit) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_W'(DEBOUNCE_TICKS)) begin
              state_n    = SCAN;
              cnt_n      = '0;
              key_held_n = 1'b0;
              col_idx_n  = col_adv;
              key_col_n  = 3'b001 << col_adv;
            end
          end else begin
            cnt_n = '0;
          end
        end
        default: state_n = SCAN;
      endcase
    end
  end

endmodule
